// File: rtl/axis_stream_monitor.sv
// Passive AXI-Stream tap: registered beat capture, per-TDEST packet/beat/byte statistics
// and sticky protocol error flags. Define AXIS_MON_WATCHDOG_EN to add the stall watchdog (err[5]).
module axis_stream_monitor #(
    parameter int DATA_WIDTH    = 32,
    parameter int ID_WIDTH      = 4,
    parameter int DEST_WIDTH    = 4,
    parameter int USER_WIDTH    = 1,
    parameter int NUM_CH        = 4,
    parameter int CNT_WIDTH     = 32,
    parameter int MAX_PKT_BEATS = 256,
    parameter int HAS_TREADY    = 1
`ifdef AXIS_MON_WATCHDOG_EN
    ,
    parameter int TIMEOUT_CYCLES = 1024
`endif
) (
    input  logic                           ACLK,
    input  logic                           ARESETn,
    input  logic                           TVALID,
    input  logic                           TREADY,
    input  logic [DATA_WIDTH-1:0]          TDATA,
    input  logic [DATA_WIDTH/8-1:0]        TSTRB,
    input  logic [DATA_WIDTH/8-1:0]        TKEEP,
    input  logic                           TLAST,
    input  logic [ID_WIDTH-1:0]            TID,
    input  logic [DEST_WIDTH-1:0]          TDEST,
    input  logic [USER_WIDTH-1:0]          TUSER,
    input  logic                           clr,
    input  logic [(NUM_CH > 1 ? $clog2(NUM_CH) : 1)-1:0] stat_sel,
    output logic                           cap_valid,
    output logic [DATA_WIDTH-1:0]          cap_data,
    output logic [DATA_WIDTH/8-1:0]        cap_strb,
    output logic [DATA_WIDTH/8-1:0]        cap_keep,
    output logic                           cap_last,
    output logic [ID_WIDTH-1:0]            cap_id,
    output logic [DEST_WIDTH-1:0]          cap_dest,
    output logic [USER_WIDTH-1:0]          cap_user,
    output logic [CNT_WIDTH-1:0]           stat_beats,
    output logic [CNT_WIDTH-1:0]           stat_pkts,
    output logic [CNT_WIDTH-1:0]           stat_bytes,
    output logic                           stat_busy,
    output logic [5:0]                     err
);
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int BC_W   = $clog2(MAX_PKT_BEATS + 1) + 1;
    localparam int KC_W   = $clog2(STRB_W + 1);
    localparam int PAY_W  = DATA_WIDTH + 2 * STRB_W + 1 + ID_WIDTH + DEST_WIDTH + USER_WIDTH;

    typedef enum logic {IDLE = 1'b0, IN_PKT = 1'b1} ch_state_t;

    logic            ready_eff, hs, stall_now;
    logic [CH_W-1:0] ch, sel;
    logic [KC_W-1:0] keep_cnt;
    logic [PAY_W-1:0] pay, pay_q;
    logic            stalled_q;
    logic            unstable_err, drop_err, strb_err, len_err, id_err, wd_err;

    ch_state_t           st_q  [NUM_CH];
    ch_state_t           st_d  [NUM_CH];
    logic [BC_W-1:0]     bc_q  [NUM_CH];
    logic [BC_W-1:0]     bc_d  [NUM_CH];
    logic [ID_WIDTH-1:0] tid_q [NUM_CH];
    logic [ID_WIDTH-1:0] tid_d [NUM_CH];
    logic [CNT_WIDTH-1:0] beats_q [NUM_CH];
    logic [CNT_WIDTH-1:0] pkts_q  [NUM_CH];
    logic [CNT_WIDTH-1:0] bytes_q [NUM_CH];

    assign ready_eff = (HAS_TREADY != 0) ? TREADY : 1'b1;
    assign hs        = TVALID & ready_eff;
    assign stall_now = TVALID & ~hs;
    assign pay       = {TDATA, TSTRB, TKEEP, TLAST, TID, TDEST, TUSER};

    generate
        if (NUM_CH > 1) begin : g_multi
            assign ch  = TDEST[CH_W-1:0];
            assign sel = stat_sel;
        end else begin : g_single
            assign ch  = '0;
            assign sel = '0;
        end
    endgenerate

    always_comb begin
        keep_cnt = '0;
        for (int i = 0; i < STRB_W; i++) keep_cnt = keep_cnt + KC_W'(TKEEP[i]);
    end

    // Per-channel packet FSM; only the channel addressed by TDEST can move on a handshake.
    always_comb begin
        len_err = 1'b0;
        id_err  = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            st_d[c]  = st_q[c];
            bc_d[c]  = bc_q[c];
            tid_d[c] = tid_q[c];
        end
        if (clr) begin
            for (int c = 0; c < NUM_CH; c++) begin
                st_d[c] = IDLE;
                bc_d[c] = '0;
            end
        end else if (hs) begin
            case (st_q[ch])
                IDLE: begin
                    if (!TLAST) begin
                        st_d[ch]  = IN_PKT;
                        bc_d[ch]  = BC_W'(1);
                        tid_d[ch] = TID;
                    end
                end
                IN_PKT: begin
                    id_err = (TID != tid_q[ch]);
                    if (TLAST) begin
                        st_d[ch] = IDLE;
                        bc_d[ch] = '0;
                    end else if (bc_q[ch] >= BC_W'(MAX_PKT_BEATS)) begin
                        len_err = 1'b1;  // overlong: stay IN_PKT, count saturates
                    end else begin
                        bc_d[ch] = bc_q[ch] + BC_W'(1);
                    end
                end
                default: st_d[ch] = IDLE;
            endcase
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            for (int c = 0; c < NUM_CH; c++) begin
                st_q[c]    <= IDLE;
                bc_q[c]    <= '0;
                tid_q[c]   <= '0;
                beats_q[c] <= '0;
                pkts_q[c]  <= '0;
                bytes_q[c] <= '0;
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                st_q[c]  <= st_d[c];
                bc_q[c]  <= bc_d[c];
                tid_q[c] <= tid_d[c];
            end
            if (clr) begin
                for (int c = 0; c < NUM_CH; c++) begin
                    beats_q[c] <= '0;
                    pkts_q[c]  <= '0;
                    bytes_q[c] <= '0;
                end
            end else if (hs) begin
                beats_q[ch] <= beats_q[ch] + CNT_WIDTH'(1);
                bytes_q[ch] <= bytes_q[ch] + CNT_WIDTH'(keep_cnt);
                if (TLAST) pkts_q[ch] <= pkts_q[ch] + CNT_WIDTH'(1);
            end
        end
    end

    // Capture path ignores clr: a beat accepted alongside clr is still reported.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            cap_valid <= 1'b0;
            cap_data  <= '0;
            cap_strb  <= '0;
            cap_keep  <= '0;
            cap_last  <= 1'b0;
            cap_id    <= '0;
            cap_dest  <= '0;
            cap_user  <= '0;
            stalled_q <= 1'b0;
            pay_q     <= '0;
        end else begin
            cap_valid <= hs;
            if (hs) begin
                cap_data <= TDATA;
                cap_strb <= TSTRB;
                cap_keep <= TKEEP;
                cap_last <= TLAST;
                cap_id   <= TID;
                cap_dest <= TDEST;
                cap_user <= TUSER;
            end
            stalled_q <= stall_now;
            pay_q     <= pay;
        end
    end

    assign unstable_err = stalled_q & TVALID & (pay != pay_q);
    assign drop_err     = stalled_q & ~TVALID;
    assign strb_err     = hs & (|(TSTRB & ~TKEEP));

`ifdef AXIS_MON_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wd_cnt;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            wd_cnt <= '0;
        end else if (clr || !stall_now) begin
            wd_cnt <= '0;
        end else if (wd_cnt != WD_W'(TIMEOUT_CYCLES)) begin
            wd_cnt <= wd_cnt + WD_W'(1);
        end
    end

    assign wd_err = stall_now && (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
`else
    assign wd_err = 1'b0;
`endif

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            err <= '0;
        end else if (clr) begin
            err <= '0;
        end else begin
            err <= err | {wd_err, id_err, len_err, strb_err, drop_err, unstable_err};
        end
    end

    assign stat_beats = beats_q[sel];
    assign stat_pkts  = pkts_q[sel];
    assign stat_bytes = bytes_q[sel];
    assign stat_busy  = (st_q[sel] == IN_PKT);

endmodule

// File: tb/tb_axis_stream_monitor.sv
// Bench for axis_stream_monitor: scoreboard on the capture port plus per-scenario statistic
// and error-flag checks. Run with AXIS_MON_WATCHDOG_EN defined to include the watchdog scenario.
module tb_axis_stream_monitor;
    localparam int PW = 32 + 4 + 4 + 1 + 4 + 4 + 1;

    logic        ACLK = 1'b0;
    logic        ARESETn = 1'b0;
    logic        TVALID = 1'b0, TREADY = 1'b0, TLAST = 1'b0;
    logic [31:0] TDATA = '0;
    logic [3:0]  TSTRB = '0, TKEEP = '0, TID = '0, TDEST = '0;
    logic [0:0]  TUSER = '0;
    logic        clr = 1'b0;
    logic [1:0]  stat_sel = '0;
    logic        cap_valid, cap_last, stat_busy;
    logic [31:0] cap_data, stat_beats, stat_pkts, stat_bytes;
    logic [3:0]  cap_strb, cap_keep, cap_id, cap_dest;
    logic [0:0]  cap_user;
    logic [5:0]  err;

    int n_vec  = 0;
    int n_miss = 0;
    logic [PW-1:0] exp_q[$];

    axis_stream_monitor #(
        .MAX_PKT_BEATS(4)
`ifdef AXIS_MON_WATCHDOG_EN
        , .TIMEOUT_CYCLES(8)
`endif
    ) dut (
        .ACLK(ACLK), .ARESETn(ARESETn), .TVALID(TVALID), .TREADY(TREADY), .TDATA(TDATA),
        .TSTRB(TSTRB), .TKEEP(TKEEP), .TLAST(TLAST), .TID(TID), .TDEST(TDEST), .TUSER(TUSER),
        .clr(clr), .stat_sel(stat_sel), .cap_valid(cap_valid), .cap_data(cap_data),
        .cap_strb(cap_strb), .cap_keep(cap_keep), .cap_last(cap_last), .cap_id(cap_id),
        .cap_dest(cap_dest), .cap_user(cap_user), .stat_beats(stat_beats), .stat_pkts(stat_pkts),
        .stat_bytes(stat_bytes), .stat_busy(stat_busy), .err(err)
    );

    // clock / reset
    always #5 ACLK = ~ACLK;

    initial begin
        #500000;
        $display("FAIL timeout: simulation time limit reached, applied %0d", n_vec);
        $fatal(1, "time limit");
    end

    // drivers
    task automatic drive(input logic v, input logic r, input logic [3:0] dest, input logic [3:0] id,
                         input logic [31:0] data, input logic [3:0] keep, input logic [3:0] strb,
                         input logic last);
        TVALID = v; TREADY = r; TDEST = dest; TID = id; TDATA = data;
        TKEEP = keep; TSTRB = strb; TLAST = last; TUSER = data[0];
        if (v && r) exp_q.push_back({data, strb, keep, last, id, dest, data[0]});
    endtask

    task automatic idle();
        TVALID = 1'b0; TREADY = 1'b1; TLAST = 1'b0;
    endtask

    // one clock; scoreboard pops one expected beat per capture pulse
    task automatic tick();
        logic [PW-1:0] got, want;
        @(posedge ACLK);
        #1;
        got = {cap_data, cap_strb, cap_keep, cap_last, cap_id, cap_dest, cap_user};
        n_vec++;
        if (exp_q.size() > 0) begin
            want = exp_q.pop_front();
            if (cap_valid !== 1'b1 || got !== want) begin
                n_miss++;
                $display("FAIL capture: cap_valid=%b got=%h want=%h", cap_valid, got, want);
            end
        end else if (cap_valid !== 1'b0) begin
            n_miss++;
            $display("FAIL capture_idle: cap_valid=%b want 0", cap_valid);
        end
    endtask

    task automatic beat(input logic [3:0] dest, input logic [3:0] id, input logic [31:0] data,
                        input logic [3:0] keep, input logic last);
        drive(1'b1, 1'b1, dest, id, data, keep, keep, last);
        tick();
    endtask

    task automatic do_clr();
        idle();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    task automatic test_reset();
        ARESETn = 1'b0;
        idle();
        tick(); tick();
        for (int s = 0; s < 4; s++) begin
            stat_sel = 2'(s);
            #1;
            n_vec++;
            if (stat_beats !== 0 || stat_pkts !== 0 || stat_bytes !== 0 || stat_busy !== 1'b0) begin
                n_miss++;
                $display("FAIL reset_stats ch%0d: beats=%0d pkts=%0d bytes=%0d busy=%b want 0",
                         s, stat_beats, stat_pkts, stat_bytes, stat_busy);
            end
        end
        n_vec++;
        if (err !== 6'd0 || cap_data !== 32'd0) begin
            n_miss++;
            $display("FAIL reset_err: err=%b cap_data=%h want 0", err, cap_data);
        end
        ARESETn = 1'b1;
        tick();
    endtask

    task automatic test_single_packet();
        logic [31:0] d;
        stat_sel = 2'd2;
        for (int b = 0; b < 3; b++) begin
            d = $urandom;
            beat(4'd2, 4'd1, d, 4'hF, b == 2);
            if (b == 1) begin
                n_vec++;
                if (stat_busy !== 1'b1 || stat_beats !== 2) begin
                    n_miss++;
                    $display("FAIL single_mid: busy=%b beats=%0d want 1/2", stat_busy, stat_beats);
                end
            end
        end
        idle();
        tick();
        n_vec++;
        if (stat_beats !== 3 || stat_pkts !== 1 || stat_bytes !== 12 || stat_busy !== 1'b0 || err !== 0) begin
            n_miss++;
            $display("FAIL single_pkt: beats=%0d pkts=%0d bytes=%0d busy=%b err=%b want 3/1/12/0/0",
                     stat_beats, stat_pkts, stat_bytes, stat_busy, err);
        end
    endtask

    task automatic test_interleave();
        logic [3:0] k;
        int b0, b1;
        logic [3:0] seq_dest [6];
        logic       seq_last [6];
        seq_dest = '{4'd1, 4'd0, 4'd1, 4'd0, 4'd1, 4'd1};
        seq_last = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        do_clr();
        b0 = 0; b1 = 0;
        for (int i = 0; i < 6; i++) begin
            k = 4'($urandom_range(1, 15));
            if (seq_dest[i] == 4'd0) b0 += $countones(k); else b1 += $countones(k);
            beat(seq_dest[i], seq_dest[i] == 4'd0 ? 4'd2 : 4'd5, $urandom, k, seq_last[i]);
        end
        idle();
        tick();
        stat_sel = 2'd0;
        #1;
        n_vec++;
        if (stat_beats !== 2 || stat_pkts !== 1 || stat_bytes !== 32'(b0)) begin
            n_miss++;
            $display("FAIL interleave_ch0: beats=%0d pkts=%0d bytes=%0d want 2/1/%0d",
                     stat_beats, stat_pkts, stat_bytes, b0);
        end
        stat_sel = 2'd1;
        #1;
        n_vec++;
        if (stat_beats !== 4 || stat_pkts !== 1 || stat_bytes !== 32'(b1) || err !== 0) begin
            n_miss++;
            $display("FAIL interleave_ch1: beats=%0d pkts=%0d bytes=%0d err=%b want 4/1/%0d/0",
                     stat_beats, stat_pkts, stat_bytes, err, b1);
        end
    endtask

    task automatic test_stall();
        do_clr();
        drive(1'b1, 1'b0, 4'd0, 4'd0, 32'hA5, 4'hF, 4'hF, 1'b1);
        tick();
        drive(1'b1, 1'b0, 4'd0, 4'd0, 32'h5A, 4'hF, 4'hF, 1'b1);
        tick();
        n_vec++;
        if (err !== 6'b000001) begin
            n_miss++;
            $display("FAIL stall_unstable: err=%b want 000001", err);
        end
        drive(1'b1, 1'b1, 4'd0, 4'd0, 32'h5A, 4'hF, 4'hF, 1'b1);
        tick();
        do_clr();
        n_vec++;
        if (err !== 6'd0) begin
            n_miss++;
            $display("FAIL stall_clr: err=%b want 0", err);
        end
        drive(1'b1, 1'b0, 4'd0, 4'd0, 32'hA5, 4'hF, 4'hF, 1'b1);
        tick();
        idle();
        tick();
        n_vec++;
        if (err !== 6'b000010) begin
            n_miss++;
            $display("FAIL stall_drop: err=%b want 000010", err);
        end
        do_clr();
    endtask

    task automatic test_strb_tid();
        drive(1'b1, 1'b1, 4'd0, 4'd0, 32'h1234, 4'b0001, 4'b0011, 1'b1);
        tick();
        idle();
        tick();
        n_vec++;
        if (err !== 6'b000100) begin
            n_miss++;
            $display("FAIL strb_keep: err=%b want 000100", err);
        end
        do_clr();
        stat_sel = 2'd3;
        beat(4'd3, 4'd1, 32'h11, 4'hF, 1'b0);
        beat(4'd3, 4'd3, 32'h22, 4'hF, 1'b1);
        idle();
        tick();
        n_vec++;
        if (err !== 6'b010000 || stat_pkts !== 1) begin
            n_miss++;
            $display("FAIL tid_change: err=%b pkts=%0d want 010000/1", err, stat_pkts);
        end
        do_clr();
    endtask

    task automatic test_max_len();
        stat_sel = 2'd1;
        for (int b = 0; b < 4; b++) beat(4'd1, 4'd4, $urandom, 4'hF, 1'b0);
        n_vec++;
        if (err !== 6'd0) begin
            n_miss++;
            $display("FAIL max_len_boundary: err=%b want 0", err);
        end
        beat(4'd1, 4'd4, $urandom, 4'hF, 1'b0);
        n_vec++;
        if (err !== 6'b001000 || stat_busy !== 1'b1 || stat_beats !== 5) begin
            n_miss++;
            $display("FAIL max_len_over: err=%b busy=%b beats=%0d want 001000/1/5", err, stat_busy, stat_beats);
        end
        idle();
        ARESETn = 1'b0;
        exp_q.delete();
        #1;
        n_vec++;
        if (cap_valid !== 0 || cap_data !== 0 || err !== 0 || stat_beats !== 0 || stat_busy !== 0) begin
            n_miss++;
            $display("FAIL async_reset: cap_valid=%b cap_data=%h err=%b beats=%0d busy=%b want 0",
                     cap_valid, cap_data, err, stat_beats, stat_busy);
        end
        tick();
        ARESETn = 1'b1;
        tick();
        beat(4'd1, 4'd7, $urandom, 4'h3, 1'b0);
        beat(4'd1, 4'd7, $urandom, 4'hF, 1'b1);
        idle();
        tick();
        n_vec++;
        if (stat_beats !== 2 || stat_pkts !== 1 || stat_bytes !== 6 || err !== 0) begin
            n_miss++;
            $display("FAIL post_reset_pkt: beats=%0d pkts=%0d bytes=%0d err=%b want 2/1/6/0",
                     stat_beats, stat_pkts, stat_bytes, err);
        end
    endtask

    task automatic test_back_to_back();
        do_clr();
        stat_sel = 2'd2;
        for (int i = 0; i < 4; i++) beat(4'd2, 4'($urandom_range(0, 15)), $urandom, 4'hF, 1'b1);
        // beat accepted together with clr: captured, not counted
        clr = 1'b1;
        drive(1'b1, 1'b1, 4'd2, 4'd0, 32'hCAFE, 4'hF, 4'hF, 1'b1);
        tick();
        clr = 1'b0;
        idle();
        tick();
        n_vec++;
        if (stat_beats !== 0 || stat_pkts !== 0 || stat_bytes !== 0) begin
            n_miss++;
            $display("FAIL clr_wins: beats=%0d pkts=%0d bytes=%0d want 0", stat_beats, stat_pkts, stat_bytes);
        end
        for (int i = 0; i < 4; i++) beat(4'd2, 4'd0, $urandom, 4'hF, 1'b1);
        idle();
        tick();
        n_vec++;
        if (stat_pkts !== 4 || stat_beats !== 4 || stat_bytes !== 16) begin
            n_miss++;
            $display("FAIL back_to_back: pkts=%0d beats=%0d bytes=%0d want 4/4/16", stat_pkts, stat_beats, stat_bytes);
        end
    endtask

`ifdef AXIS_MON_WATCHDOG_EN
    task automatic test_watchdog();
        do_clr();
        for (int c = 0; c < 8; c++) begin
            drive(1'b1, 1'b0, 4'd0, 4'd0, 32'h77, 4'hF, 4'hF, 1'b1);
            tick();
            if (c == 6) begin
                n_vec++;
                if (err[5] !== 1'b0) begin
                    n_miss++;
                    $display("FAIL wd_early: err5=%b want 0", err[5]);
                end
            end
        end
        n_vec++;
        if (err !== 6'b100000) begin
            n_miss++;
            $display("FAIL wd_timeout: err=%b want 100000", err);
        end
        drive(1'b1, 1'b1, 4'd0, 4'd0, 32'h77, 4'hF, 4'hF, 1'b1);
        tick();
        do_clr();
        for (int c = 0; c < 7; c++) begin
            drive(1'b1, 1'b0, 4'd0, 4'd0, 32'h88, 4'hF, 4'hF, 1'b1);
            tick();
        end
        drive(1'b1, 1'b1, 4'd0, 4'd0, 32'h88, 4'hF, 4'hF, 1'b1);
        tick();
        idle();
        tick();
        n_vec++;
        if (err !== 6'd0) begin
            n_miss++;
            $display("FAIL wd_7_stalls: err=%b want 0", err);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_packet();
        test_interleave();
        test_stall();
        test_strb_tid();
        test_max_len();
        test_back_to_back();
`ifdef AXIS_MON_WATCHDOG_EN
        test_watchdog();
`endif
        idle();
        tick();
        if (exp_q.size() != 0) begin
            n_miss++;
            $display("FAIL leftover: %0d expected beats never captured", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
